i2c_target_rx: RTL and testbench



---
 rtl/i2c_target_rx.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: START/STOP detect, 7-bit address match,
// ACK/NACK drive, byte handoff. Optional: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_bad
      $error("i2c_target_rx: illegal parameter value");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;

  // Bring both bus lines into the clk domain; idle bus reads high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [1:0]    raw;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];

  assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

  // A line only moves once the new level has held FILTER_LEN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != filt[i]) begin
          if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
            filt[i] <= raw[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign scl_s = filt[1];
  assign sda_s = filt[0];
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  logic scl_q;
  logic sda_q;

  // Previous sample of each line for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic scl_edge;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign scl_edge  = scl_rise | scl_fall;
  // An SCL edge in the same cycle masks any SDA edge.
  assign start_det = ~scl_edge & scl_s & ~sda_s & sda_q;
  assign stop_det  = ~scl_edge & scl_s & sda_s & ~sda_q;

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] shreg;
  logic [7:0] nxt;
  logic       ack;
  logic       hold;

  assign nxt = {shreg, sda_s};

  // Protocol FSM; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      ack      <= 1'b0;
      hold     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        cnt     <= '0;
        hold    <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        overrun <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= '0;
        hold   <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, IGNORE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shreg <= nxt[6:0];
              if (cnt == 4'd7) begin
                cnt  <= 4'd8;
                hold <= 1'b0;
                if (nxt[7:1] == TARGET_ADDR && !nxt[0]) begin
                  state <= ADDR_ACK;
                  ack   <= 1'b1;
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shreg <= nxt[6:0];
              if (cnt == 4'd7) begin
                cnt   <= 4'd8;
                hold  <= 1'b0;
                state <= DATA_ACK;
                if (rx_ready) begin
                  rx_data  <= nxt;
                  rx_valid <= 1'b1;
                  ack      <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                  ack     <= 1'b0;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!hold) begin
                hold   <= 1'b1;
                sda_oe <= ack;
              end else begin
                hold   <= 1'b0;
                sda_oe <= 1'b0;
                cnt    <= '0;
                state  <= DATA;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master with
// open-drain SDA, byte/ACK checks and handshake monitoring.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad = 0;

  int         pulses = 0;
  int         vcyc = 0;
  int         oe_cnt = 0;
  logic       prev_v = 1'b0;
  logic [7:0] got [$];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx dut (
    .clk(clk),
    .reset(reset),
    .scl_in(scl_m),
    .sda_in(sda_bus),
    .sda_oe(sda_oe),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy(busy),
    .overrun(overrun)
  );

  // Record every rx_valid pulse and every cycle ACK is driven.
  always @(posedge clk) begin
    if (rx_valid) begin
      vcyc++;
      if (!prev_v) begin
        pulses++;
        got.push_back(rx_data);
      end
    end
    prev_v = rx_valid;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wclk(50);
    scl_m = 1'b1;
    wclk(50);
    sda_m = 1'b0;
    wclk(50);
    scl_m = 1'b0;
    wclk(50);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wclk(50);
    scl_m = 1'b1;
    wclk(50);
    sda_m = 1'b1;
    wclk(50);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    wclk(50);
    scl_m = 1'b1;
    wclk(100);
    scl_m = 1'b0;
    wclk(50);
  endtask

  task automatic read_ack(output logic a);
    sda_m = 1'b1;
    wclk(50);
    scl_m = 1'b1;
    wclk(50);
    a = ~sda_bus;
    wclk(50);
    scl_m = 1'b0;
    wclk(50);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_ack(a);
  endtask

  logic a;
  int   p0, v0, o0, g0;
  logic [7:0] lastb;

  initial begin
    wclk(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    wclk(20);

    // Write 0x50 / 0xA5 with an exact rx_valid latency check.
    p0 = pulses; g0 = got.size();
    i2c_start();
    write_byte(8'hA0, a);
    check("t1_addr_ack", a, 1'b1);
    check("t1_busy", busy, 1'b1);
    lastb = 8'hA5;
    for (int i = 7; i >= 1; i--) write_bit(lastb[i]);
    sda_m = lastb[0];
    wclk(50);
    scl_m = 1'b1;
    wclk(2);
    check("t1_lat_early", rx_valid, 1'b0);
    wclk(1);
    check("t1_lat_on", rx_valid, 1'b1);
    check("t1_lat_data", rx_data, 8'hA5);
    wclk(1);
    check("t1_lat_off", rx_valid, 1'b0);
    wclk(96);
    scl_m = 1'b0;
    wclk(50);
    read_ack(a);
    check("t1_data_ack", a, 1'b1);
    check("t1_busy_hold", busy, 1'b1);
    i2c_stop();
    wclk(10);
    check("t1_busy_stop", busy, 1'b0);
    check("t1_pulses", pulses - p0, 1);
    check("t1_got", got[g0], 8'hA5);

    // Wrong address: nothing driven, nothing delivered.
    p0 = pulses; o0 = oe_cnt;
    i2c_start();
    write_byte(8'hA2, a);
    check("t2_addr_nack", a, 1'b0);
    check("t2_busy", busy, 1'b0);
    write_byte(8'h3C, a);
    check("t2_data_nack", a, 1'b0);
    i2c_stop();
    wclk(10);
    check("t2_oe_cycles", oe_cnt - o0, 0);
    check("t2_pulses", pulses - p0, 0);
    check("t2_busy_end", busy, 1'b0);

    // Read request to our address is NACKed and ignored.
    p0 = pulses; o0 = oe_cnt;
    i2c_start();
    write_byte(8'hA1, a);
    check("t3_rd_nack", a, 1'b0);
    write_byte(8'h55, a);
    check("t3_ign_nack", a, 1'b0);
    check("t3_busy", busy, 1'b0);
    i2c_stop();
    wclk(10);
    check("t3_oe_cycles", oe_cnt - o0, 0);
    check("t3_pulses", pulses - p0, 0);

    // Three bytes, middle one refused by local logic.
    p0 = pulses; g0 = got.size();
    i2c_start();
    write_byte(8'hA0, a);
    check("t4_addr_ack", a, 1'b1);
    write_byte(8'h01, a);
    check("t4_b1_ack", a, 1'b1);
    rx_ready = 1'b0;
    write_byte(8'h02, a);
    check("t4_b2_nack", a, 1'b0);
    check("t4_overrun", overrun, 1'b1);
    check("t4_data_keep", rx_data, 8'h01);
    rx_ready = 1'b1;
    write_byte(8'h03, a);
    check("t4_b3_ack", a, 1'b1);
    i2c_stop();
    wclk(10);
    check("t4_pulses", pulses - p0, 2);
    check("t4_got0", got[g0], 8'h01);
    check("t4_got1", got[g0+1], 8'h03);
    check("t4_sticky", overrun, 1'b1);

    // Next START clears overrun; then a repeated START mid-byte.
    p0 = pulses; g0 = got.size();
    i2c_start();
    check("t5_ovr_clr", overrun, 1'b0);
    write_byte(8'hA0, a);
    check("t5_addr_ack", a, 1'b1);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_start();
    check("t5_busy_rs", busy, 1'b0);
    write_byte(8'hA0, a);
    check("t5_addr2_ack", a, 1'b1);
    write_byte(8'h7E, a);
    check("t5_data_ack", a, 1'b1);
    check("t5_rx_data", rx_data, 8'h7E);
    i2c_stop();
    wclk(10);
    check("t5_pulses", pulses - p0, 1);
    check("t5_got", got[g0], 8'h7E);

    // Asynchronous reset while ACK is being driven.
    i2c_start();
    lastb = 8'hA0;
    for (int i = 7; i >= 0; i--) write_bit(lastb[i]);
    sda_m = 1'b1;
    wclk(50);
    check("t6_oe_before", sda_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_oe_async", sda_oe, 1'b0);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_overrun", overrun, 1'b0);
    check("t6_rx_valid", rx_valid, 1'b0);
    wclk(5);
    reset = 1'b0;
    wclk(20);
    i2c_stop();
    wclk(20);
    p0 = pulses; g0 = got.size();
    i2c_start();
    write_byte(8'hA0, a);
    check("t6_re_addr", a, 1'b1);
    write_byte(8'h96, a);
    check("t6_re_data", a, 1'b1);
    i2c_stop();
    wclk(10);
    check("t6_re_pulses", pulses - p0, 1);
    check("t6_re_got", got[g0], 8'h96);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // A 1-cycle SDA dip with SCL high must not look like START.
    sda_m = 1'b0;
    wclk(1);
    sda_m = 1'b1;
    wclk(20);
    check("t7_busy", busy, 1'b0);
    scl_m = 1'b0;
    wclk(50);
    write_byte(8'hA0, a);
    check("t7_no_ack", a, 1'b0);
    i2c_stop();
    wclk(10);
`endif

    check("vld_width", vcyc, pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
